router_port_rx: RTL and testbench
=================================

ROUTER_PORT_RX -- requirements
Module: router_port_rx

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 16, giving the width of router flits.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, giving the receive buffer depth; legal values are powers of two, 2 to 64.
REQ-003 Port clk, input, 1 bit: the single clock; every state element updates on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port router_data_i, input, DATA_WIDTH bits: flit from a router destination port (any *_data_o).
REQ-006 Port router_enable_i, input, 1 bit: flit-valid from the same router port (*_enable_o); there is no return flow control.
REQ-007 Port pe_data_o, output, DATA_WIDTH bits: head-of-FIFO flit presented to the consumer (PE or GLB).
REQ-008 Port pe_valid_o, output, 1 bit: pe_data_o holds a valid flit.
REQ-009 Port pe_ready_i, input, 1 bit: the consumer accepts pe_data_o this cycle.
REQ-010 Port full_o, output, 1 bit: the FIFO holds FIFO_DEPTH flits.
REQ-011 Port empty_o, output, 1 bit: the FIFO holds 0 flits.
REQ-012 Port count_o, output, $clog2(FIFO_DEPTH)+1 bits: current occupancy.
REQ-013 Port overflow_o, output, 1 bit: sticky flag, set when a flit has been dropped.

Function
REQ-014 push is defined as router_enable_i AND (NOT full_o OR pop), sampled at the rising edge of clk.
REQ-015 pop is defined as pe_valid_o AND pe_ready_i.
REQ-016 On push, the module SHALL write router_data_i at the write pointer and advance the pointer modulo FIFO_DEPTH.
REQ-017 On pop, the module SHALL advance the read pointer modulo FIFO_DEPTH.
REQ-018 pe_data_o SHALL be the storage entry at the read pointer, first-word-fall-through, driven from registers with no combinational path from router_data_i.
REQ-019 pe_valid_o SHALL equal NOT empty_o.
REQ-020 Latency: a flit pushed at edge N SHALL appear on pe_data_o/pe_valid_o after edge N; there is no same-cycle bypass when the FIFO is empty.
REQ-021 count_o SHALL increment on push only, decrement on pop only, and hold on simultaneous push and pop; full_o and empty_o SHALL be derived from count_o.
REQ-022 When full, a push and pop in the same cycle SHALL both be accepted; count stays FIFO_DEPTH and no flit is dropped.
REQ-023 When router_enable_i=1 while full_o=1 and pop=0, the flit SHALL be discarded, storage and pointers SHALL be unchanged, and overflow_o SHALL be set on that edge.
REQ-024 overflow_o SHALL remain 1 until reset.
REQ-025 When pe_ready_i=1 while empty, the module SHALL have no effect.
REQ-026 Flit order SHALL be preserved across pointer wrap-around.

Reset
REQ-027 On reset=1 at a rising edge, the module SHALL clear read pointer, write pointer, count_o and overflow_o to 0, making empty_o=1, full_o=0 and pe_valid_o=0; storage contents are don't-care.
REQ-028 Reset SHALL take priority over a concurrent push or pop; a flit presented during the reset cycle is lost.
REQ-029 A reset asserted mid-operation SHALL discard all buffered flits.

Configuration
REQ-030 When macro ROUTER_PORT_RX_DROP_CNT_EN is defined, the module SHALL add output drop_count_o (8 bits, reset 0); it increments on each discarded flit (REQ-023) and saturates at 255.
REQ-031 When ROUTER_PORT_RX_DROP_CNT_EN is undefined, drop_count_o and its counter SHALL not exist; all other behaviour is identical.

Verification
REQ-032 Reset, then push 0x0001, 0x0002, 0x0003 with pe_ready_i=0 -> count_o=3; pe_data_o=0x0001 one cycle after the first push.
REQ-033 DEPTH=4, push 0xA0..0xA3, then push 0xA4 with no pop -> full_o=1, overflow_o=1, 0xA4 dropped; draining yields 0xA0..0xA3 in order.
REQ-034 Full FIFO, push 0xB0 with pe_ready_i=1 in the same cycle -> 0xA0 popped, 0xB0 stored, count_o=4, overflow_o unchanged.
REQ-035 Stream 10 flits 0x10..0x19 with pe_ready_i=1 throughout -> 10 pops in order, wrap-around correct, count_o never exceeds 1.
REQ-036 Reset mid-stream with count_o=3 -> next cycle empty_o=1, pe_valid_o=0, overflow_o=0.
REQ-037 With ROUTER_PORT_RX_DROP_CNT_EN defined, 300 dropped flits -> drop_count_o=255.

Source files
------------

// File: rtl/router_port_rx.sv
// router_port_rx: receive buffer between a router destination port and its
// consumer (PE or GLB). The router side has no back-pressure, so flits that
// arrive while the buffer is full and nothing drains are dropped. Each drop
// sets a sticky overflow flag.
//
// Optional feature: define ROUTER_PORT_RX_DROP_CNT_EN to add drop_count_o.
// This is an 8-bit count of dropped flits that saturates at 255.
//
// Consumer handshake (valid/ready): pe_valid_o is high whenever the buffer
// holds a flit, and pe_data_o then shows the oldest flit. A transfer happens
// on the rising edge where pe_valid_o and pe_ready_i are both 1. pe_valid_o
// does not depend on pe_ready_i. pe_data_o stays stable until it is taken.
// pe_ready_i has no effect while pe_valid_o is 0.
module router_port_rx #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         router_data_i,
    input  logic                          router_enable_i,
    output logic [DATA_WIDTH-1:0]         pe_data_o,
    output logic                          pe_valid_o,
    input  logic                          pe_ready_i,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o,
    output logic                          overflow_o
`ifdef ROUTER_PORT_RX_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_count_o
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;
    logic                  push;
    logic                  pop;
    logic                  drop;

    // Occupancy flags come from the counter only.
    assign count_o    = count_q;
    assign full_o     = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o    = (count_q == '0);
    assign pe_valid_o = ~empty_o;
    assign overflow_o = overflow_q;

    // Head entry is read straight from storage, so a flit that arrives while
    // the buffer is empty becomes visible only after its write edge.
    assign pe_data_o = mem[rd_ptr];

    // When the buffer is full, a pop in the same cycle frees a slot for the
    // incoming flit. Without that pop, the incoming flit is dropped.
    always_comb begin
        pop  = pe_valid_o & pe_ready_i;
        push = router_enable_i & (~full_o | pop);
        drop = router_enable_i & full_o & ~pop;
    end

    // Storage write. Storage is not reset because only entries between the
    // pointers are ever observed.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= router_data_i;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    // Occupancy counter: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky overflow flag: only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
        end else if (drop) begin
            overflow_q <= 1'b1;
        end
    end

`ifdef ROUTER_PORT_RX_DROP_CNT_EN
    logic [7:0] drop_cnt_q;

    assign drop_count_o = drop_cnt_q;

    // Saturating count of dropped flits.
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_router_port_rx.sv
// Bench for router_port_rx.
// The reference model is an ordered queue of expected flits plus an integer
// occupancy, a sticky overflow bit and a saturating drop tally.
// The driver adds a flit to the queue once its push edge has passed.
// A negedge monitor compares the DUT head flit with the front of the queue
// and removes that entry when the consumer takes it.
module tb_router_port_rx;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] router_data_i;
    logic          router_enable_i;
    logic [DW-1:0] pe_data_o;
    logic          pe_valid_o;
    logic          pe_ready_i;
    logic          full_o;
    logic          empty_o;
    logic [CW-1:0] count_o;
    logic          overflow_o;
`ifdef ROUTER_PORT_RX_DROP_CNT_EN
    logic [7:0]    drop_count_o;
`endif

    logic [DW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            m_count;
    bit            m_ovf;
    int            m_drops;
    int            max_count;
    bit            mon_en = 1'b0;

    router_port_rx #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .router_data_i   (router_data_i),
        .router_enable_i (router_enable_i),
        .pe_data_o       (pe_data_o),
        .pe_valid_o      (pe_valid_o),
        .pe_ready_i      (pe_ready_i),
        .full_o          (full_o),
        .empty_o         (empty_o),
        .count_o         (count_o),
        .overflow_o      (overflow_o)
`ifdef ROUTER_PORT_RX_DROP_CNT_EN
        ,
        .drop_count_o    (drop_count_o)
`endif
    );

    // Clock generation.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: checks the head flit and retires it when it is taken.
    always @(negedge clk) begin
        if (mon_en && pe_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid actual=%0h required=none at %0t", pe_data_o, $time);
            end else begin
                chk("head_flit", 32'(pe_data_o), 32'(exp_q[0]));
                if (pe_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    // One clock cycle of stimulus, followed by checks against the model.
    task automatic step(input bit en, input logic [DW-1:0] d, input bit rdy);
        bit pop_m, push_m, drop_m;
        router_enable_i = en;
        router_data_i   = d;
        pe_ready_i      = rdy;
        pop_m  = rdy && (m_count > 0);
        push_m = en && ((m_count < DEPTH) || pop_m);
        drop_m = en && !push_m;
        @(posedge clk);
        #1;
        if (push_m) exp_q.push_back(d);
        m_count = m_count + int'(push_m) - int'(pop_m);
        if (m_count > max_count) max_count = m_count;
        if (drop_m) begin
            m_ovf = 1'b1;
            if (m_drops < 255) m_drops++;
        end
        chk("count", 32'(count_o), 32'(m_count));
        chk("full", 32'(full_o), 32'(m_count == DEPTH));
        chk("empty", 32'(empty_o), 32'(m_count == 0));
        chk("valid", 32'(pe_valid_o), 32'(m_count != 0));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
`ifdef ROUTER_PORT_RX_DROP_CNT_EN
        chk("drop_count", 32'(drop_count_o), 32'(m_drops));
`endif
    endtask

    // Reset with a push and a ready held during the reset cycle.
    // Both of those are expected to be ignored.
    task automatic do_reset();
        mon_en          = 1'b0;
        reset           = 1'b1;
        router_enable_i = 1'b1;
        router_data_i   = DW'($urandom);
        pe_ready_i      = 1'b1;
        @(posedge clk);
        #1;
        reset           = 1'b0;
        router_enable_i = 1'b0;
        pe_ready_i      = 1'b0;
        exp_q.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_drops = 0;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_valid", 32'(pe_valid_o), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
`ifdef ROUTER_PORT_RX_DROP_CNT_EN
        chk("rst_drop_count", 32'(drop_count_o), 32'd0);
`endif
        mon_en = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1);
    endtask

    initial begin
        reset = 1'b1;
        router_enable_i = 1'b0;
        router_data_i = '0;
        pe_ready_i = 1'b0;
        m_count = 0;
        m_ovf = 1'b0;
        m_drops = 0;
        max_count = 0;
        @(posedge clk);
        #1;
        do_reset();

        // Three pushes with the consumer stalled.
        step(1'b1, 16'h0001, 1'b0);
        step(1'b1, 16'h0002, 1'b0);
        step(1'b1, 16'h0003, 1'b0);
        drain();
        // A ready while the buffer is empty must have no effect.
        step(1'b0, 16'h0000, 1'b1);

        // Fill the buffer, then push one more flit, which must be dropped.
        for (int i = 0; i < 4; i++) step(1'b1, 16'(16'hA0 + i), 1'b0);
        step(1'b1, 16'h00A4, 1'b0);
        // With the buffer full, a push and a pop in the same cycle both succeed.
        step(1'b1, 16'h00B0, 1'b1);
        drain();

        // Stream ten flits with the consumer always ready.
        do_reset();
        max_count = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 16'(16'h10 + i), 1'b1);
        chk("stream_max_count", 32'(max_count), 32'd1);
        drain();

        // Reset while three flits are buffered.
        for (int i = 0; i < 3; i++) step(1'b1, 16'(16'h30 + i), 1'b0);
        do_reset();
        step(1'b0, 16'h0000, 1'b1);

        // Random traffic. The ready probability alternates between phases
        // so that both the full and empty boundaries are exercised.
        for (int i = 0; i < 600; i++) begin
            int rdy_pct;
            rdy_pct = ((i / 50) % 2 == 0) ? 20 : 80;
            step($urandom_range(0, 99) < 65, DW'($urandom), $urandom_range(0, 99) < rdy_pct);
        end
        drain();

        // Fill the buffer, then offer 300 flits with no pops.
        do_reset();
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 300; i++) step(1'b1, DW'($urandom), 1'b0);
        drain();

        // Every pushed flit must have been consumed by the end of the run.
        chk("queue_empty_at_end", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
